fetch_sequencer: RTL and testbench

Program-counter sequencer that sits directly upstream of the instruction memory. It drives the 6-bit byte address each cycle and advances it by 4, or redirects it on branch, jump or jump-register. It samples the memory's combinational halt flag to freeze fetch permanently until reset. An optional counter tracks retired instructions.

---
 rtl/fetch_sequencer_pkg.sv | 17 +
 rtl/fetch_sequencer_if.sv | 29 ++
 rtl/fetch_sequencer_retire_counter.sv | 18 +
 rtl/fetch_sequencer.sv | 110 +++++++++++
 tb/tb_fetch_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and helpers for the fetch sequencer.
// Holds the fetch FSM state type, the PC step and the branch offset helper.
package mips_fetch_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam int PC_STEP = 4;

  // Word offset to byte offset: sign-extend the 16-bit immediate and scale by 4.
  function automatic logic signed [31:0] branch_offset(input logic signed [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: redirect/stall/halt controls in, fetch address and status out.
// master = the sequencer, slave = the surrounding pipeline / instruction memory.
interface fetch_sequencer_if #(
  parameter int PC_W = 6
);
  logic                stall;
  logic                halt;
  logic                branch_taken;
  logic signed [15:0]  branch_imm;
  logic                jump;
  logic [25:0]         jump_index;
  logic                jr;
  logic [31:0]         jr_target;
  logic [PC_W-1:0]     pc;
  logic [PC_W-1:0]     pc_plus4;
  logic                halted;
  logic                align_err;
  logic [15:0]         retired;

  modport master (
    input  stall, halt, branch_taken, branch_imm, jump, jump_index, jr, jr_target,
    output pc, pc_plus4, halted, align_err, retired
  );

  modport slave (
    output stall, halt, branch_taken, branch_imm, jump, jump_index, jr, jr_target,
    input  pc, pc_plus4, halted, align_err, retired
  );
endinterface

// File: rtl/fetch_sequencer_retire_counter.sv
// 16-bit saturating event counter with increment enable and async active-low reset.
module fetch_retire_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  // Count enabled events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer feeding the instruction memory.
// Advances pc by 4 or redirects on jr/jump/branch; freezes permanently on halt.
// Optional retired-instruction counter: define FETCH_PERF_CNT_EN to build it,
// otherwise retired reads as zero.
module fetch_sequencer #(
  parameter int              PC_W     = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);
  import mips_fetch_pkg::*;

  fetch_state_t    state_p1;
  logic [PC_W-1:0] pc_p1;
  logic            halted_p1;
  logic            align_err_p1;

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] jmp_tgt;
  logic [PC_W-1:0] jr_tgt;
  logic [PC_W-1:0] pc_nxt;
  logic            go_halt;
  logic            misalign;
  logic            unused_bits;

  assign pc_plus4 = pc_p1 + PC_W'(PC_STEP);
  assign br_tgt   = pc_plus4 + PC_W'(branch_offset(bus.branch_imm));
  assign jmp_tgt  = {bus.jump_index[PC_W-3:0], 2'b00};
  assign jr_tgt   = {bus.jr_target[PC_W-1:2], 2'b00};

  // Address bits above the fetch window are dropped by the modulo-2^PC_W wrap.
  assign unused_bits = ^{bus.jr_target[31:PC_W], bus.jump_index[25:PC_W-2]};

  // Next-PC selection: halt beats jr beats jump beats branch beats sequential.
  always_comb begin
    pc_nxt   = pc_p1;
    go_halt  = 1'b0;
    misalign = 1'b0;
    if ((state_p1 == RUN) && !bus.stall) begin
      if (bus.halt) begin
        go_halt = 1'b1;
      end else if (bus.jr) begin
        pc_nxt   = jr_tgt;
        misalign = |bus.jr_target[1:0];
      end else if (bus.jump) begin
        pc_nxt = jmp_tgt;
      end else if (bus.branch_taken) begin
        pc_nxt = br_tgt;
      end else begin
        pc_nxt = pc_plus4;
      end
    end
  end

  // Fetch FSM: RUN until halt is seen unstalled, then HALTED until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1     <= RUN;
      pc_p1        <= RESET_PC;
      halted_p1    <= 1'b0;
      align_err_p1 <= 1'b0;
    end else begin
      pc_p1 <= pc_nxt;
      if (misalign) begin
        align_err_p1 <= 1'b1;
      end
      case (state_p1)
        RUN: begin
          if (go_halt) begin
            state_p1  <= HALTED;
            halted_p1 <= 1'b1;
          end
        end
        HALTED: begin
          state_p1  <= HALTED;
          halted_p1 <= 1'b1;
        end
        default: begin
          state_p1  <= HALTED;
          halted_p1 <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc        = pc_p1;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.halted    = halted_p1;
  assign bus.align_err = align_err_p1;

`ifdef FETCH_PERF_CNT_EN
  logic adv;

  // Every unstalled, non-halting cycle in RUN retires one instruction.
  assign adv = (state_p1 == RUN) && !bus.stall && !bus.halt;

  fetch_retire_counter u_retire (
    .clk   (clk),
    .rst   (rst),
    .inc   (adv),
    .count (bus.retired)
  );
`else
  assign bus.retired = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against a behavioural model.
module tb_fetch_sequencer;

  localparam int PC_W = 6;
  localparam int PC_MOD = 64;

  logic clk;
  logic rst;

  fetch_sequencer_if #(.PC_W(PC_W)) bus ();

  fetch_sequencer #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int m_pc;
  bit m_halted;
  bit m_align;
  int m_ret;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wrap(input int v);
    return ((v % PC_MOD) + PC_MOD) % PC_MOD;
  endfunction

  task automatic model_reset();
    m_pc     = 0;
    m_halted = 1'b0;
    m_align  = 1'b0;
    m_ret    = 0;
  endtask

  // One rising edge of the architectural rules.
  task automatic model_edge();
    if (!m_halted && !bus.stall) begin
      if (bus.halt) begin
        m_halted = 1'b1;
      end else begin
        if (bus.jr) begin
          m_pc = ((bus.jr_target % PC_MOD) / 4) * 4;
          if ((bus.jr_target % 4) != 0) m_align = 1'b1;
        end else if (bus.jump) begin
          m_pc = wrap((bus.jump_index % PC_MOD) * 4);
        end else if (bus.branch_taken) begin
          m_pc = wrap(m_pc + 4 + int'(bus.branch_imm) * 4);
        end else begin
          m_pc = wrap(m_pc + 4);
        end
`ifdef FETCH_PERF_CNT_EN
        if (m_ret < 65535) m_ret++;
`endif
      end
    end
  endtask

  task automatic check_all();
    chk("pc",        32'(bus.pc),        32'(m_pc));
    chk("pc_plus4",  32'(bus.pc_plus4),  32'(wrap(m_pc + 4)));
    chk("halted",    32'(bus.halted),    32'(m_halted));
    chk("align_err", 32'(bus.align_err), 32'(m_align));
    chk("retired",   32'(bus.retired),   32'(m_ret));
  endtask

  task automatic set_in(input bit st, input bit hl, input bit br, input logic [15:0] imm,
                        input bit jp, input logic [25:0] idx, input bit r, input logic [31:0] tgt);
    bus.stall        = st;
    bus.halt         = hl;
    bus.branch_taken = br;
    bus.branch_imm   = imm;
    bus.jump         = jp;
    bus.jump_index   = idx;
    bus.jr           = r;
    bus.jr_target    = tgt;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
  endtask

  // Advance one clock, update the model, then check 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Async reset applied between edges; outputs must clear immediately.
  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int exp_ret;
    rst = 1'b0;
    idle();
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;

    // Free run: 0,4,...,60,0
    for (int k = 1; k <= 17; k++) begin
      step();
      chk("freerun_pc", 32'(bus.pc), 32'((4 * k) % 64));
      if (k == 16) begin
`ifdef FETCH_PERF_CNT_EN
        exp_ret = 16;
`else
        exp_ret = 0;
`endif
        chk("retired_16", 32'(bus.retired), 32'(exp_ret));
      end
    end

    // Branch backwards and branch with wrap
    async_reset();
    step(); step();
    chk("at_pc8", 32'(bus.pc), 32'd8);
    set_in(0, 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0);
    step();
    chk("branch_back", 32'(bus.pc), 32'd4);
    idle();
    for (int k = 0; k < 14; k++) step();
    chk("at_pc60", 32'(bus.pc), 32'd60);
    set_in(0, 0, 1, 16'h0001, 0, 26'h0, 0, 32'h0);
    step();
    chk("branch_wrap", 32'(bus.pc), 32'd4);

    // Jump beats branch; then misaligned jr
    set_in(0, 0, 1, 16'h0003, 1, 26'd5, 0, 32'h0);
    step();
    chk("jump_wins", 32'(bus.pc), 32'd20);
    set_in(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h2A);
    step();
    chk("jr_pc", 32'(bus.pc), 32'd40);
    chk("jr_align", 32'(bus.align_err), 32'd1);
    idle();
    step();
    chk("align_sticky", 32'(bus.align_err), 32'd1);

    // Stall masks halt and jump; halt then freezes fetch
    async_reset();
    step(); step(); step();
    chk("at_pc12", 32'(bus.pc), 32'd12);
    set_in(1, 1, 0, 16'h0, 1, 26'd7, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", 32'(bus.pc), 32'd12);
      chk("stall_halted", 32'(bus.halted), 32'd0);
    end
    set_in(0, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    step();
    chk("halt_rise", 32'(bus.halted), 32'd1);
    for (int k = 0; k < 4; k++) begin
      set_in(k[0], k[1], 1, 16'h0005, 1, 26'd9, 0, 32'h0);
      step();
      chk("halt_hold_pc", 32'(bus.pc), 32'd12);
    end
    set_in(0, 0, 0, 16'h0, 1, 26'd3, 1, 32'h31);
    step();
    chk("halt_ignore_redirect", 32'(bus.pc), 32'd12);
    async_reset();
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    idle();

    // Randomized phase
    for (int i = 0; i < 800; i++) begin
      set_in(($urandom % 4) == 0,
             ($urandom % 48) == 0,
             ($urandom % 4) == 0,
             16'($urandom),
             ($urandom % 6) == 0,
             26'($urandom),
             ($urandom % 8) == 0,
             $urandom);
      step();
      if ((($urandom % 60) == 0) || (m_halted && (($urandom % 6) == 0))) begin
        async_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
